// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the ID-stage hazard detection unit:
//   REG_ZERO           architectural $zero, never a real dependency
//   MD_LATENCY_DEFAULT default mul/div occupancy in cycles
//   stall_cause_t      per-cause stall vector, also brought out for debug
//   reg_match()        "does the ID instruction read register r" helper
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam logic [4:0] REG_ZERO           = 5'd0;
  localparam int         MD_LATENCY_DEFAULT = 32;

  typedef struct packed {
    logic load_use;   // load in EX feeds a source of the ID instruction
    logic br_ex;      // branch operand still being computed in EX
    logic br_mem;     // branch operand still being loaded in MEM
    logic md_hazard;  // mul/div or HI/LO access while the unit is busy
  } stall_cause_t;

  // A writer of r is a dependency only if r is not $zero and the ID
  // instruction actually reads it (rt only counts when it is a source).
  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_md_busy_counter.sv
// -----------------------------------------------------------------------------
// md_busy_counter
// Tracks how many more cycles the multi-cycle mul/div unit stays occupied.
// Loads MD_LATENCY on issue, counts down to zero and holds there.
// Ports:
//   clk       pipeline clock
//   rst_n     synchronous reset, active low (abandons any operation)
//   i_load    a mul/div issues this cycle (only possible while idle)
//   o_md_cnt  remaining busy cycles
//   o_busy    unit occupied (o_md_cnt != 0)
// -----------------------------------------------------------------------------
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int MD_CNT_W   = $clog2(MD_LATENCY + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  output logic [MD_CNT_W-1:0] o_md_cnt,
  output logic                o_busy
);

  localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(MD_LATENCY);

  logic [MD_CNT_W-1:0] r_md_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_md_cnt <= '0;
    end else if (i_load) begin
      // Issue is only granted while idle, so load never races a decrement.
      r_md_cnt <= LOAD_VAL;
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - 1'b1;
    end
  end

  assign o_md_cnt = r_md_cnt;
  assign o_busy   = (r_md_cnt != '0);

endmodule

// File: rtl/hazard_detect_unit.sv
// -----------------------------------------------------------------------------
// hazard_detect_unit
// ID-stage stall/flush controller for the 5-stage MIPS pipeline. Covers the
// hazards the EX forwarding unit cannot: load-use, branch operands that are
// not ready when the branch resolves in ID, and HI/LO or mul/div use while
// the multi-cycle mul/div unit is occupied. Outputs are combinational
// (zero latency) from inputs and the registered state.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   IFID_RegisterRs/Rt         source registers of the ID instruction
//   IFID_UsesRt                ID instruction reads rt
//   IFID_Branch                ID instruction is beq/bne
//   IFID_MulDiv                ID instruction is mult/multu/div/divu
//   IFID_ReadsHiLo             ID instruction is mfhi/mflo
//   Branch_Taken               ID branch comparison resolved taken
//   IDEX_MemRead/RegWrite/Rd   EX instruction is a load / writes Rd
//   EXMEM_MemRead/Rd           MEM instruction is a load into Rd
//   PCWrite, IFID_Write        PC and IF/ID load enables
//   IFID_Flush                 squash the fetched instruction
//   IDEX_Bubble                zero ID/EX control bits
//   MD_Busy                    mul/div unit occupied
//   Stall_Count                saturating count of stall cycles
//   Stall_Cause                per-cause stall vector (debug)
// -----------------------------------------------------------------------------
module hazard_detect_unit
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IFID_RegisterRs,
  input  logic [4:0]       IFID_RegisterRt,
  input  logic             IFID_UsesRt,
  input  logic             IFID_Branch,
  input  logic             IFID_MulDiv,
  input  logic             IFID_ReadsHiLo,
  input  logic             Branch_Taken,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic [4:0]       IDEX_RegisterRd,
  input  logic             EXMEM_MemRead,
  input  logic [4:0]       EXMEM_RegisterRd,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             MD_Busy,
  output logic [CNT_W-1:0] Stall_Count,
  output stall_cause_t     Stall_Cause
);

  localparam int MD_CNT_W = $clog2(MD_LATENCY + 1);

  logic [MD_CNT_W-1:0] w_md_cnt;
  logic                w_md_busy;
  logic                w_match_ex;
  logic                w_match_mem;
  stall_cause_t        w_cause;
  logic                w_stall;
  logic                w_md_issue;
  logic [CNT_W-1:0]    r_stall_count;

  assign w_match_ex  = reg_match(IDEX_RegisterRd, IFID_RegisterRs,
                                 IFID_RegisterRt, IFID_UsesRt);
  assign w_match_mem = reg_match(EXMEM_RegisterRd, IFID_RegisterRs,
                                 IFID_RegisterRt, IFID_UsesRt);

  // Every cause is gated by rst_n so the pipeline runs freely in reset,
  // whatever the (possibly stale) stage inputs say.
  // NOTE: each always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_cause           = '0;
    w_cause.load_use  = rst_n && IDEX_MemRead && w_match_ex;
    w_cause.br_ex     = rst_n && IFID_Branch && IDEX_RegWrite && w_match_ex;
    w_cause.br_mem    = rst_n && IFID_Branch && EXMEM_MemRead && w_match_mem;
    w_cause.md_hazard = rst_n && w_md_busy && (IFID_MulDiv || IFID_ReadsHiLo);
  end

  assign w_stall    = |w_cause;
  assign w_md_issue = rst_n && IFID_MulDiv && !w_stall;

  md_busy_counter #(
    .MD_LATENCY (MD_LATENCY),
    .MD_CNT_W   (MD_CNT_W)
  ) u_md_busy_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_md_issue),
    .o_md_cnt (w_md_cnt),
    .o_busy   (w_md_busy)
  );

  // Pipeline control. A branch seen while stalling has unresolved operands,
  // so its taken flag must not squash the fetched instruction yet.
  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    if (w_stall) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end else begin
      IFID_Flush  = rst_n && Branch_Taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign MD_Busy     = rst_n && w_md_busy;
  assign Stall_Count = r_stall_count;
  assign Stall_Cause = w_cause;

endmodule

// File: tb/tb_hazard_detect_unit.sv
module tb_hazard_detect_unit;
  import hazard_pkg::*;

  localparam int MD_LATENCY = 4;
  localparam int CNT_W      = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       rs, rt, idex_rd, exmem_rd;
  logic             uses_rt, branch, muldiv, hilo, taken;
  logic             idex_memread, idex_regwrite, exmem_memread;
  logic             pcwrite, ifid_write, ifid_flush, idex_bubble, md_busy;
  logic [CNT_W-1:0] stall_count;
  stall_cause_t     stall_cause;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_detect_unit #(.MD_LATENCY(MD_LATENCY), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .IFID_RegisterRs  (rs),
    .IFID_RegisterRt  (rt),
    .IFID_UsesRt      (uses_rt),
    .IFID_Branch      (branch),
    .IFID_MulDiv      (muldiv),
    .IFID_ReadsHiLo   (hilo),
    .Branch_Taken     (taken),
    .IDEX_MemRead     (idex_memread),
    .IDEX_RegWrite    (idex_regwrite),
    .IDEX_RegisterRd  (idex_rd),
    .EXMEM_MemRead    (exmem_memread),
    .EXMEM_RegisterRd (exmem_rd),
    .PCWrite          (pcwrite),
    .IFID_Write       (ifid_write),
    .IFID_Flush       (ifid_flush),
    .IDEX_Bubble      (idex_bubble),
    .MD_Busy          (md_busy),
    .Stall_Count      (stall_count),
    .Stall_Cause      (stall_cause)
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       ut, br, md, hl, tk, em, ew;
    logic [4:0] erd;
    logic       mm;
    logic [4:0] mrd;
    logic       xs, xf, xb;   // expected stall, flush, busy
    logic [3:0] xc;           // expected Stall_Count
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, input logic [4:0] rs_i, input logic [4:0] rt_i,
                             input logic ut, input logic br, input logic md, input logic hl,
                             input logic tk, input logic em, input logic ew, input logic [4:0] erd,
                             input logic mm, input logic [4:0] mrd,
                             input logic xs, input logic xf, input logic xb, input logic [3:0] xc);
    vec_t r;
    r.rst = rst; r.rs = rs_i; r.rt = rt_i; r.ut = ut; r.br = br; r.md = md; r.hl = hl;
    r.tk = tk; r.em = em; r.ew = ew; r.erd = erd; r.mm = mm; r.mrd = mrd;
    r.xs = xs; r.xf = xf; r.xb = xb; r.xc = xc;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    rst_n = t.rst; rs = t.rs; rt = t.rt; uses_rt = t.ut; branch = t.br;
    muldiv = t.md; hilo = t.hl; taken = t.tk; idex_memread = t.em;
    idex_regwrite = t.ew; idex_rd = t.erd; exmem_memread = t.mm; exmem_rd = t.mrd;
  endtask

  task automatic idle_inputs();
    drive(v(1, 0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
  endtask

  int stalls;
  bit done;

  initial begin
    //            rst rs rt ut br md hl tk em ew erd mm mrd  xs xf xb xc
    // reset overrides a would-be load-use, mflo and taken branch
    tbl.push_back(v(0, 8, 0, 0, 0, 0, 1, 1, 1, 1, 8, 1, 8,  0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    // load-use on rs: one stall, count 0 -> 1
    tbl.push_back(v(1, 8, 0, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0,  1, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1));
    // load into $0 is never a dependency
    tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 1));
    // rt matters only when it is a source
    tbl.push_back(v(1, 3, 9, 1, 0, 0, 0, 0, 1, 1, 9, 0, 0,  1, 0, 0, 1));
    tbl.push_back(v(1, 3, 9, 0, 0, 0, 0, 0, 1, 1, 9, 0, 0,  0, 0, 0, 2));
    // lw $9 ; beq $9 : br_ex then br_mem, taken ignored, then flush
    tbl.push_back(v(1, 9, 0, 1, 1, 0, 0, 1, 1, 1, 9, 0, 0,  1, 0, 0, 2));
    tbl.push_back(v(1, 9, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 9,  1, 0, 0, 3));
    tbl.push_back(v(1, 9, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0,  0, 1, 0, 4));
    // ALU result in EX feeding branch rt stalls; non-branch forwards
    tbl.push_back(v(1, 4, 5, 1, 1, 0, 0, 0, 0, 1, 5, 0, 0,  1, 0, 0, 4));
    tbl.push_back(v(1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0,  0, 0, 0, 5));
    tbl.push_back(v(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5,  0, 0, 0, 5));
    // mult then mflo: 4 stalls, busy 4 cycles, mflo issues on the 5th
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 5));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 5));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 6));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 7));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 8));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 9));
    // back-to-back mul/div chain drives the counter into saturation
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 9));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 9));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 10));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 11));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 12));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 13));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 13));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 14));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 15));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 15));
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 15));
    // mflo stalls (md_cnt=4); reset at md_cnt=3 clears everything
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 15));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 15));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    // writer of $0 feeding a taken branch: no stall, flush
    tbl.push_back(v(1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0,  0, 1, 0, 0));

    drive(v(0, 0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      @(negedge clk);
      check($sformatf("v%0d PCWrite", i),     int'(pcwrite),     int'(!tbl[i].xs));
      check($sformatf("v%0d IFID_Write", i),  int'(ifid_write),  int'(!tbl[i].xs));
      check($sformatf("v%0d IDEX_Bubble", i), int'(idex_bubble), int'(tbl[i].xs));
      check($sformatf("v%0d IFID_Flush", i),  int'(ifid_flush),  int'(tbl[i].xf));
      check($sformatf("v%0d MD_Busy", i),     int'(md_busy),     int'(tbl[i].xb));
      check($sformatf("v%0d Stall_Count", i), int'(stall_count), int'(tbl[i].xc));
    end

    // Hand sequence: reset, mult, then mflo held until it issues.
    @(posedge clk); #1;
    drive(v(0, 0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    @(posedge clk); #1;
    idle_inputs();
    muldiv = 1'b1;
    @(negedge clk);
    check("seq mult issues", int'(pcwrite), 1);
    @(posedge clk); #1;
    muldiv = 1'b0;
    hilo   = 1'b1;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (pcwrite) done = 1'b1;
      else begin
        stalls++;
        @(posedge clk); #1;
      end
    end
    check("seq mflo issued within bound", int'(done), 1);
    check("seq mflo stall cycles", stalls, MD_LATENCY);
    check("seq Stall_Count", int'(stall_count), MD_LATENCY);
    check("seq MD_Busy after drain", int'(md_busy), 0);

    // Load-use with the mul/div unit idle while mflo also in ID: exactly one stall.
    @(posedge clk); #1;
    idle_inputs();
    hilo = 1'b1; rs = 5'd12; idex_memread = 1'b1; idex_rd = 5'd12;
    @(negedge clk);
    check("seq load_use cause", int'(stall_cause.load_use), 1);
    check("seq md_hazard idle", int'(stall_cause.md_hazard), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
